// File: rtl/microsequencer.sv
// Microsequencer next-state engine: selects and registers the next microstate,
// with a single-level call/return register, a memory-wait watchdog and an illegal-state clamp.
module microsequencer #(
  parameter int         NUM_STATES  = 37,
  parameter logic [6:0] FAULT_STATE = 7'd0,
  parameter int         MAX_WAIT    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] next_sel,
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  input  logic [6:0] cr_addr,
  input  logic [6:0] enc_addr,
  input  logic       moc,
  input  logic       cond_flag,
  output logic [6:0] current_state,
  output logic [6:0] ret_state,
  output logic       mem_timeout,
  output logic       illegal_state
);

  localparam logic [2:0] SEL_ENC  = 3'b000;
  localparam logic [2:0] SEL_INC  = 3'b001;
  localparam logic [2:0] SEL_JMP  = 3'b010;
  localparam logic [2:0] SEL_BR   = 3'b011;
  localparam logic [2:0] SEL_WAIT = 3'b100;
  localparam logic [2:0] SEL_CALL = 3'b101;
  localparam logic [2:0] SEL_RET  = 3'b110;
  localparam logic [2:0] SEL_RST  = 3'b111;

  localparam logic [7:0] NUM_STATES_W = 8'(NUM_STATES);
  // The hold that would bring the count up to MAX_WAIT is the one that times out.
  localparam logic [7:0] WAIT_LIMIT   = 8'(MAX_WAIT - 1);

  logic [6:0] current_state_q, current_state_d;
  logic [6:0] ret_state_q, ret_state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       illegal_state_q, illegal_state_d;

  logic       cond_src;
  logic       cond;
  logic       hold;
  logic [6:0] inc;
  logic [6:0] raw_target;

  function automatic logic is_illegal(input logic [6:0] s);
    return {1'b0, s} >= NUM_STATES_W;
  endfunction

  function automatic logic [6:0] clamp_state(input logic [6:0] s);
    return is_illegal(s) ? 7'd0 : s;
  endfunction

  always_comb begin
    cond_src = 1'b0;
    case (cond_sel)
      2'b00:   cond_src = moc;
      2'b01:   cond_src = cond_flag;
      2'b10:   cond_src = 1'b1;
      default: cond_src = 1'b0;
    endcase
    cond = cond_src ^ cond_inv;
    inc  = current_state_q + 7'd1;
    hold = (next_sel == SEL_WAIT) && !cond;

    raw_target = 7'd0;
    case (next_sel)
      SEL_ENC:  raw_target = enc_addr;
      SEL_INC:  raw_target = inc;
      SEL_JMP:  raw_target = cr_addr;
      SEL_BR:   raw_target = cond ? cr_addr : inc;
      SEL_WAIT: raw_target = cond ? inc : current_state_q;
      SEL_CALL: raw_target = cr_addr;
      SEL_RET:  raw_target = ret_state_q;
      SEL_RST:  raw_target = 7'd0;
      default:  raw_target = 7'd0;
    endcase

    ret_state_d = ret_state_q;
    if (next_sel == SEL_CALL) ret_state_d = clamp_state(inc);

    if (hold && (wait_cnt_q == WAIT_LIMIT)) begin
      // Watchdog wins over the clamp; FAULT_STATE is trusted as-is.
      current_state_d = FAULT_STATE;
      mem_timeout_d   = 1'b1;
      illegal_state_d = 1'b0;
      wait_cnt_d      = 8'd0;
    end else begin
      current_state_d = clamp_state(raw_target);
      mem_timeout_d   = 1'b0;
      illegal_state_d = is_illegal(raw_target);
      wait_cnt_d      = hold ? wait_cnt_q + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_state_q <= 7'd0;
      ret_state_q     <= 7'd0;
      wait_cnt_q      <= 8'd0;
      mem_timeout_q   <= 1'b0;
      illegal_state_q <= 1'b0;
    end else begin
      current_state_q <= current_state_d;
      ret_state_q     <= ret_state_d;
      wait_cnt_q      <= wait_cnt_d;
      mem_timeout_q   <= mem_timeout_d;
      illegal_state_q <= illegal_state_d;
    end
  end

  assign current_state = current_state_q;
  assign ret_state     = ret_state_q;
  assign mem_timeout   = mem_timeout_q;
  assign illegal_state = illegal_state_q;

endmodule

// File: tb/tb_microsequencer.sv
// Testbench for microsequencer: directed vector table, watchdog/reset sequences,
// then randomized traffic checked against a behavioural model.
module tb_microsequencer;

  localparam int NUM_STATES = 37;
  localparam int FAULT      = 0;
  localparam int MAX_WAIT   = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] next_sel;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [6:0] cr_addr;
  logic [6:0] enc_addr;
  logic       moc;
  logic       cond_flag;
  logic [6:0] current_state;
  logic [6:0] ret_state;
  logic       mem_timeout;
  logic       illegal_state;

  microsequencer #(
    .NUM_STATES (NUM_STATES),
    .FAULT_STATE(7'(FAULT)),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .next_sel     (next_sel),
    .cond_sel     (cond_sel),
    .cond_inv     (cond_inv),
    .cr_addr      (cr_addr),
    .enc_addr     (enc_addr),
    .moc          (moc),
    .cond_flag    (cond_flag),
    .current_state(current_state),
    .ret_state    (ret_state),
    .mem_timeout  (mem_timeout),
    .illegal_state(illegal_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] ns;
    logic [1:0] cs;
    logic       ci;
    logic [6:0] cr;
    logic [6:0] enc;
    logic       mc;
    logic       cf;
    int         e_st;
    int         e_ret;
    int         e_to;
    int         e_ill;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model: plain integer view of the sequencing rules.
  int m_cur = 0, m_ret = 0, m_waits = 0, m_to = 0, m_ill = 0;

  function automatic vec_t mk(input int rst, ns, cs, ci, cr, enc, mc, cf,
                              input int st, rt, to, ill);
    vec_t v;
    v.rst = rst[0]; v.ns = ns[2:0]; v.cs = cs[1:0]; v.ci = ci[0];
    v.cr = cr[6:0]; v.enc = enc[6:0]; v.mc = mc[0]; v.cf = cf[0];
    v.e_st = st; v.e_ret = rt; v.e_to = to; v.e_ill = ill;
    return v;
  endfunction

  task automatic model_step();
    int c, nxt, tgt, sel;
    sel = int'(next_sel);
    if (reset) begin
      m_cur = 0; m_ret = 0; m_waits = 0; m_to = 0; m_ill = 0;
      return;
    end
    case (cond_sel)
      2'd0: c = int'(moc);
      2'd1: c = int'(cond_flag);
      2'd2: c = 1;
      default: c = 0;
    endcase
    if (cond_inv) c = 1 - c;
    nxt = (m_cur + 1) % 128;
    if (sel == 4 && c == 0 && m_waits + 1 == MAX_WAIT) begin
      m_cur = FAULT; m_to = 1; m_ill = 0; m_waits = 0;
      return;
    end
    case (sel)
      0: tgt = int'(enc_addr);
      1: tgt = nxt;
      2: tgt = int'(cr_addr);
      3: tgt = c ? int'(cr_addr) : nxt;
      4: tgt = c ? nxt : m_cur;
      5: tgt = int'(cr_addr);
      6: tgt = m_ret;
      default: tgt = 0;
    endcase
    if (sel == 5) m_ret = (nxt < NUM_STATES) ? nxt : 0;
    m_waits = (sel == 4 && c == 0) ? m_waits + 1 : 0;
    m_ill = (tgt >= NUM_STATES) ? 1 : 0;
    m_cur = m_ill ? 0 : tgt;
    m_to = 0;
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; next_sel = v.ns; cond_sel = v.cs; cond_inv = v.ci;
    cr_addr = v.cr; enc_addr = v.enc; moc = v.mc; cond_flag = v.cf;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int st, rt, to, ill);
    n_checks++;
    if (int'(current_state) == st && int'(ret_state) == rt &&
        int'(mem_timeout) == to && int'(illegal_state) == ill) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got st=%0d ret=%0d to=%0d ill=%0d, expected st=%0d ret=%0d to=%0d ill=%0d",
               name, current_state, ret_state, mem_timeout, illegal_state, st, rt, to, ill);
    end
  endtask

  initial begin
    vec_t v;
    int   burst;
    reset = 1'b1; next_sel = 3'd1; cond_sel = 2'd0; cond_inv = 1'b0;
    cr_addr = 7'd0; enc_addr = 7'd0; moc = 1'b0; cond_flag = 1'b0;

    //          rst ns cs ci  cr enc mc cf   st ret to ill
    tbl.push_back(mk(1, 1, 0, 0,  0,  0, 0, 0,   0,  0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0,  0, 0, 0,   0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0,   1,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0,   2,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0,   3,  0, 0, 0));
    tbl.push_back(mk(0, 7, 0, 0,  0,  0, 0, 0,   0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0,   1,  0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0,   1,  0, 0, 0));
    tbl.push_back(mk(0, 4, 0, 0,  0,  0, 1, 0,   2,  0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0,  6,  0, 0, 0,   6,  0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 0, 16,  0, 0, 1,  16,  0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0,  6,  0, 0, 0,   6,  0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 0, 16,  0, 0, 0,   7,  0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0,  6,  0, 0, 0,   6,  0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 16,  0, 0, 0,  16,  0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 10,  0, 0, 0,  10,  0, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 34,  0, 0, 0,  34, 11, 0, 0));
    tbl.push_back(mk(0, 6, 0, 0,  0,  0, 0, 0,  11, 11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 50, 0, 0,   0, 11, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 17, 0, 0,  17, 11, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 40,  0, 0, 0,   0, 18, 0, 1));
    tbl.push_back(mk(0, 6, 0, 0,  0,  0, 0, 0,  18, 18, 0, 0));
    tbl.push_back(mk(0, 4, 2, 0,  0,  0, 0, 0,  19, 18, 0, 0));
    tbl.push_back(mk(0, 3, 3, 0,  5,  0, 0, 0,  20, 18, 0, 0));
    tbl.push_back(mk(0, 3, 3, 1,  5,  0, 0, 0,   5, 18, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 36,  0, 0, 0,  36, 18, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0,  0, 0, 0,   0, 18, 0, 1));
    tbl.push_back(mk(0, 2, 0, 0, 36,  0, 0, 0,  36, 18, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0,  3,  0, 0, 0,   3,  0, 0, 0));
    tbl.push_back(mk(0, 6, 0, 0,  0,  0, 0, 0,   0,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_ret, tbl[i].e_to, tbl[i].e_ill);
    end

    // Watchdog: from state 2, MAX_WAIT-1 holds stay put, the next one faults.
    apply(mk(0, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    check("wd_start", 2, 0, 0, 0);
    for (int i = 1; i < MAX_WAIT; i++) begin
      apply(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check($sformatf("wd_hold%0d", i), 2, 0, 0, 0);
    end
    apply(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("wd_timeout", FAULT, 0, 1, 0);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("wd_pulse_end", FAULT + 1, 0, 0, 0);

    // Reset mid-wait must clear the counter: a full budget of holds follows.
    apply(mk(0, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) apply(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_midwait", 0, 0, 0, 0);
    apply(mk(0, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < MAX_WAIT; i++) apply(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_cnt_clear", 2, 0, 0, 0);
    apply(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_then_timeout", FAULT, 0, 1, 0);

    // Randomized traffic against the model, with bursts of memory waits.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst = ($urandom_range(0, 199) == 0);
      v.cr  = 7'($urandom_range(0, 45));
      v.enc = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 36));
      v.cf  = 1'($urandom_range(0, 1));
      if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(8, 24);
      if (burst > 0) begin
        burst--;
        v.ns = 3'd4; v.cs = 2'd0; v.ci = 1'b0;
        v.mc = ($urandom_range(0, 19) == 0);
      end else begin
        v.ns = 3'($urandom_range(0, 7));
        v.cs = 2'($urandom_range(0, 3));
        v.ci = 1'($urandom_range(0, 1));
        v.mc = 1'($urandom_range(0, 1));
      end
      apply(v);
      check($sformatf("rand%0d", i), m_cur, m_ret, m_to, m_ill);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
